cpu: RTL and testbench

- Single-cycle 32-bit, 16-register CPU core. Executes the word on `instruction` each cycle; the instruction is supplied externally, addressed by `pc`.
- Holds its own register file and a small internal data memory.
- Exposes register-read values, control signals and key datapath mux outputs for debug and verification.
- Sits under the SoC top, which owns instruction fetch.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_control.sv | 39 +++
 rtl/cpu.sv | 98 +++++++++
 tb/tb_cpu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU codes, instruction field positions and an immediate helper
package cpu_pkg;
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 28;
    localparam int RD_HI  = 27;
    localparam int RD_LO  = 24;
    localparam int RA_HI  = 23;
    localparam int RA_LO  = 20;
    localparam int RB_HI  = 19;
    localparam int RB_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_LUI  = 4'hD;
    localparam logic [3:0] OP_SLTI = 4'hE;
    localparam logic [3:0] OP_JAL  = 4'hF;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLL   = 4'd6;
    localparam logic [3:0] ALU_PASSB = 4'd8;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction
endpackage

// File: rtl/cpu_control.sv
// cpu_control: combinational opcode decoder for mux selects, write enable and ALU code
module cpu_control
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       M1,
    output logic       M2,
    output logic       M3,
    output logic       M4,
    output logic       M5,
    output logic       M6,
    output logic       Wr_en,
    output logic [3:0] ALU,
    output logic       is_beq,
    output logic       is_bne
);
    always_comb begin
        M1     = opcode inside {OP_BEQ, OP_BNE, OP_SW};
        M2     = opcode inside {OP_LW, OP_SW, OP_ADDI, OP_LUI, OP_SLTI};
        M3     = opcode == OP_LUI;
        M4     = opcode == OP_LW;
        M5     = opcode == OP_JAL;
        M6     = opcode == OP_JAL;
        Wr_en  = opcode inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SLT, OP_SLL,
                                OP_LW, OP_ADDI, OP_LUI, OP_SLTI, OP_JAL};
        is_beq = opcode == OP_BEQ;
        is_bne = opcode == OP_BNE;
        case (opcode)
            OP_AND:          ALU = ALU_AND;
            OP_OR:           ALU = ALU_OR;
            OP_XOR:          ALU = ALU_XOR;
            OP_SUB:          ALU = ALU_SUB;
            OP_SLT, OP_SLTI: ALU = ALU_SLT;
            OP_SLL:          ALU = ALU_SLL;
            OP_LUI:          ALU = ALU_PASSB;
            default:         ALU = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/cpu.sv
// cpu: single-cycle 32-bit, 16-register core with inline register file, ALU and data memory
module cpu
    import cpu_pkg::*;
#(
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] Ra_rf,
    output logic [31:0] Rb_rf,
    output logic        M1,
    output logic        M2,
    output logic        M3,
    output logic        M4,
    output logic        M5,
    output logic        M6,
    output logic        M7,
    output logic        Wr_en,
    output logic        Eq,
    output logic [3:0]  ALU,
    output logic [31:0] mux3_out,
    output logic [31:0] mux4_out1,
    output logic [31:0] mux5_out1,
    output logic [31:0] mux6_out
);
    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0] regs [16];
    logic [31:0] dmem [DMEM_WORDS];
    logic [3:0]  opcode, rd, ra, rb, rb_sel;
    logic [15:0] imm;
    logic [31:0] alu_b, alu_y, pc_inc;
    logic        is_beq, is_bne;

    assign opcode = instruction[OP_HI:OP_LO];
    assign rd     = instruction[RD_HI:RD_LO];
    assign ra     = instruction[RA_HI:RA_LO];
    assign rb     = instruction[RB_HI:RB_LO];
    assign imm    = instruction[IMM_HI:IMM_LO];

    cpu_control u_control (
        .opcode (opcode),
        .M1     (M1),
        .M2     (M2),
        .M3     (M3),
        .M4     (M4),
        .M5     (M5),
        .M6     (M6),
        .Wr_en  (Wr_en),
        .ALU    (ALU),
        .is_beq (is_beq),
        .is_bne (is_bne)
    );

    assign rb_sel    = M1 ? rd : rb;
    assign Ra_rf     = ra == 4'd0 ? '0 : regs[ra];
    assign Rb_rf     = rb_sel == 4'd0 ? '0 : regs[rb_sel];
    assign Eq        = Ra_rf == Rb_rf;
    assign M7        = (is_beq & Eq) | (is_bne & ~Eq);
    assign mux3_out  = M3 ? {imm, 16'h0} : sext16(imm);
    assign alu_b     = M2 ? mux3_out : Rb_rf;
    assign pc_inc    = pc + 32'd1;

    always_comb begin
        case (ALU)
            ALU_ADD:   alu_y = Ra_rf + alu_b;
            ALU_SUB:   alu_y = Ra_rf - alu_b;
            ALU_AND:   alu_y = Ra_rf & alu_b;
            ALU_OR:    alu_y = Ra_rf | alu_b;
            ALU_XOR:   alu_y = Ra_rf ^ alu_b;
            ALU_SLT:   alu_y = {31'd0, $signed(Ra_rf) < $signed(alu_b)};
            ALU_SLL:   alu_y = Ra_rf << alu_b[4:0];
            ALU_PASSB: alu_y = alu_b;
            default:   alu_y = '0;
        endcase
    end

    assign mux4_out1 = M4 ? dmem[alu_y[AW-1:0]] : alu_y;
    assign mux5_out1 = M5 ? pc_inc : mux4_out1;
    assign mux6_out  = M6 ? {16'h0, imm} : (M7 ? pc_inc + sext16(imm) : pc_inc);

    // data memory keeps its contents across reset but never writes while in reset
    always_ff @(posedge clk) begin
        if (rst && opcode == OP_SW) dmem[alu_y[AW-1:0]] <= Rb_rf;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            pc <= mux6_out;
            if (Wr_en && rd != 4'd0) regs[rd] <= mux5_out1;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: randomized scoreboard bench; a behavioural model predicts each cycle's outputs
module tb_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] pc, Ra_rf, Rb_rf, mux3_out, mux4_out1, mux5_out1, mux6_out;
    logic        M1, M2, M3, M4, M5, M6, M7, Wr_en, Eq;
    logic [3:0]  ALU;

    cpu #(.DMEM_WORDS(64)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc),
        .Ra_rf(Ra_rf), .Rb_rf(Rb_rf), .M1(M1), .M2(M2), .M3(M3), .M4(M4),
        .M5(M5), .M6(M6), .M7(M7), .Wr_en(Wr_en), .Eq(Eq), .ALU(ALU),
        .mux3_out(mux3_out), .mux4_out1(mux4_out1), .mux5_out1(mux5_out1),
        .mux6_out(mux6_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins, pc, a, b, imm_ext, res, npc;
        logic [6:0]  sel;
        logic        wr, eq, chk_alu, chk_mem;
        logic [3:0]  alu;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] m_regs [16];
    logic [31:0] m_dmem [64];
    logic [31:0] m_pc;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string nm, input logic [31:0] ins, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s ins=%h: got %h expected %h", nm, ins, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_pc = '0;
    endtask

    // predict the cycle's outputs from instruction semantics, then retire it if not in reset
    task automatic issue(input logic [31:0] ins);
        exp_t        x;
        logic [3:0]  op, rd, ra, rb;
        logic [15:0] imm;
        logic [31:0] sx, addr;
        logic        taken;
        op = ins[31:28]; rd = ins[27:24]; ra = ins[23:20]; rb = ins[19:16]; imm = ins[15:0];
        sx = {{16{imm[15]}}, imm};
        x.ins = ins;
        x.pc = m_pc;
        x.a = m_regs[ra];
        x.b = (op == 4'h8 || op == 4'h9 || op == 4'hB) ? m_regs[rd] : m_regs[rb];
        x.eq = x.a == x.b;
        addr = x.a + sx;
        x.imm_ext = op == 4'hD ? {imm, 16'h0} : sx;
        case (op)
            4'h1: x.res = x.a & x.b;
            4'h2: x.res = x.a | x.b;
            4'h3: x.res = x.a ^ x.b;
            4'h4: x.res = x.a + x.b;
            4'h5: x.res = x.a - x.b;
            4'h6: x.res = $signed(x.a) < $signed(x.b) ? 32'd1 : 32'd0;
            4'h7: x.res = x.a << x.b[4:0];
            4'hA: x.res = m_dmem[addr % 64];
            4'hB: x.res = addr;
            4'hC: x.res = addr;
            4'hD: x.res = {imm, 16'h0};
            4'hE: x.res = $signed(x.a) < $signed(sx) ? 32'd1 : 32'd0;
            4'hF: x.res = m_pc + 1;
            default: x.res = '0;
        endcase
        x.wr = !(op == 4'h0 || op == 4'h8 || op == 4'h9 || op == 4'hB);
        taken = (op == 4'h8 && x.eq) || (op == 4'h9 && !x.eq);
        x.npc = op == 4'hF ? {16'h0, imm} : (taken ? m_pc + 1 + sx : m_pc + 1);
        x.sel = {op == 4'h8 || op == 4'h9 || op == 4'hB,
                 op >= 4'hA && op <= 4'hE,
                 op == 4'hD, op == 4'hA, op == 4'hF, op == 4'hF, taken};
        x.chk_alu = !(op == 4'h8 || op == 4'h9 || op == 4'hF);
        x.chk_mem = op == 4'hA || op == 4'hB;
        case (op)
            4'h1: x.alu = 4'd2;
            4'h2: x.alu = 4'd3;
            4'h3: x.alu = 4'd4;
            4'h5: x.alu = 4'd1;
            4'h6, 4'hE: x.alu = 4'd5;
            4'h7: x.alu = 4'd6;
            4'hD: x.alu = 4'd8;
            default: x.alu = 4'd0;
        endcase
        instruction = ins;
        q.push_back(x);
        if (rst) begin
            if (x.wr && rd != 0) m_regs[rd] = x.res;
            if (op == 4'hB) m_dmem[addr % 64] = x.b;
            m_pc = x.npc;
        end
    endtask

    task automatic cyc(input logic [31:0] ins, input logic r);
        @(posedge clk);
        #2;
        rst = r;
        if (!r) model_reset();
        issue(ins);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", e.ins, pc, e.pc);
            chk("Ra_rf", e.ins, Ra_rf, e.a);
            chk("Rb_rf", e.ins, Rb_rf, e.b);
            chk("Eq", e.ins, {31'd0, Eq}, {31'd0, e.eq});
            chk("M1..M7", e.ins, {25'd0, M1, M2, M3, M4, M5, M6, M7}, {25'd0, e.sel});
            chk("Wr_en", e.ins, {31'd0, Wr_en}, {31'd0, e.wr});
            chk("mux3_out", e.ins, mux3_out, e.imm_ext);
            chk("mux6_out", e.ins, mux6_out, e.npc);
            if (e.chk_alu) chk("ALU", e.ins, {28'd0, ALU}, {28'd0, e.alu});
            if (e.wr) chk("mux5_out1", e.ins, mux5_out1, e.res);
            if (e.chk_mem) chk("mux4_out1", e.ins, mux4_out1, e.res);
        end
    end

    initial begin
        logic [31:0] ins;
        model_reset();
        cyc(32'h00000000, 1'b0);
        cyc(32'hC1230001, 1'b1);
        cyc(32'hC2230002, 1'b1);
        cyc(32'h43210000, 1'b1);
        cyc(32'h54230000, 1'b1);
        cyc(32'h81200000, 1'b1);
        cyc(32'h81100004, 1'b1);
        cyc(32'hD300FFFF, 1'b1);
        cyc(32'hB3000005, 1'b1);
        cyc(32'hA6000005, 1'b1);
        cyc(32'hF7000010, 1'b1);
        cyc(32'h00000000, 1'b1);
        for (int i = 0; i < 64; i++) begin
            cyc({8'hD5, 8'h00, 16'($urandom)}, 1'b1);
            cyc({12'hC55, 4'h0, 16'($urandom)}, 1'b1);
            cyc({8'hB5, 8'h00, 16'(i)}, 1'b1);
        end
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            if (n == 300) begin
                cyc(32'hC1110005, 1'b0);
                cyc(32'hF2000033, 1'b0);
                cyc(32'h43110000, 1'b1);
            end
            if ((ins[31:28] == 4'h8 || ins[31:28] == 4'h9) && ins[0]) ins[23:20] = ins[27:24];
            cyc(ins, 1'b1);
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
